// File: rtl/risc16_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RISC-16 datapath.
// Define RISC16_PERF_CNT_EN to add the cyc_cnt/ret_cnt performance counters.
module risc16_seq_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] op,
    input  logic       halt_insn,
    input  logic       EQ,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       IR_we,
    output logic       PC_we,
    output logic [1:0] FUNC_alu,
    output logic       MUX_alu1,
    output logic       MUX_alu2,
    output logic [1:0] MUX_pc,
    output logic       MUX_rf,
    output logic [1:0] MUX_tgt,
    output logic       WE_rf,
    output logic       WE_dmem,
    output logic       halted,
    output logic       err
`ifdef RISC16_PERF_CNT_EN
    ,
    output logic [15:0] cyc_cnt,
    output logic [15:0] ret_cnt
`endif
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_NAND = 3'd2,
        OP_LUI  = 3'd3,
        OP_SW   = 3'd4,
        OP_LW   = 3'd5,
        OP_BEQ  = 3'd6,
        OP_JALR = 3'd7
    } opcode_e;

    state_e        state_q, state_d;
    opcode_e       op_q;
    logic          halt_q;
    logic [CW-1:0] wait_q, wait_d;
    logic          timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (wait_q == CW'(TIMEOUT));

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_DECODE: state_d = halt_insn ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (op_q)
                    OP_BEQ:       state_d = S_FETCH;
                    OP_LW, OP_SW: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_WB:          state_d = S_FETCH;
            S_HALT, S_ERR: state_d = state_q;
            default:       state_d = S_ERR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= OP_ADD;
            halt_q  <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE) begin
                op_q   <= opcode_e'(op);
                halt_q <= halt_insn;
            end
        end
    end

    // Outputs decode state and op_q only; reset forces every output low so an
    // aborted instruction never leaves a write enable behind.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        IR_we    = 1'b0;
        PC_we    = 1'b0;
        FUNC_alu = 2'b00;
        MUX_alu1 = 1'b0;
        MUX_alu2 = 1'b0;
        MUX_pc   = 2'b00;
        MUX_rf   = 1'b0;
        MUX_tgt  = 2'b00;
        WE_rf    = 1'b0;
        WE_dmem  = 1'b0;
        halted   = 1'b0;
        err      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    IR_we    = imem_ready;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_NAND: FUNC_alu = 2'b01;
                        OP_LUI: begin
                            FUNC_alu = 2'b10;
                            MUX_alu1 = 1'b1;
                        end
                        OP_LW, OP_SW: MUX_alu2 = 1'b1;
                        OP_BEQ: begin
                            FUNC_alu = 2'b11;
                            MUX_rf   = 1'b1;
                            PC_we    = 1'b1;
                            MUX_pc   = EQ ? 2'b01 : 2'b00;
                        end
                        OP_JALR: FUNC_alu = 2'b10;
                        default: FUNC_alu = 2'b00;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    WE_dmem  = (op_q == OP_SW);
                    PC_we    = (op_q == OP_SW) && dmem_ready;
                end
                S_WB: begin
                    WE_rf = 1'b1;
                    PC_we = 1'b1;
                    case (op_q)
                        OP_LW:   MUX_tgt = 2'b00;
                        OP_JALR: MUX_tgt = 2'b10;
                        default: MUX_tgt = 2'b01;
                    endcase
                    MUX_pc = (op_q == OP_JALR) ? 2'b10 : 2'b00;
                end
                S_HALT: halted = halt_q;
                S_ERR:  err = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef RISC16_PERF_CNT_EN
    logic [15:0] cyc_q, ret_q;
    logic        run;

    assign run = (state_q != S_HALT) && (state_q != S_ERR);

    // Every PC_we is the last one of its instruction, so it marks retirement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else if (run) begin
            cyc_q <= cyc_q + 16'd1;
            if (PC_we) begin
                ret_q <= ret_q + 16'd1;
            end
        end
    end

    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_risc16_seq_ctrl.sv
// Self-checking bench for risc16_seq_ctrl: per-cycle expected output traces
// built instruction by instruction from the sequencing rules.
module tb_risc16_seq_ctrl;

    localparam int unsigned TO = 4;

    localparam logic [2:0] ADD = 3'd0, ADDI = 3'd1, NAND = 3'd2, LUI = 3'd3,
                           SW = 3'd4, LW = 3'd5, BEQ = 3'd6, JALR = 3'd7;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] func_alu;
        logic       mux_alu1;
        logic       mux_alu2;
        logic [1:0] mux_pc;
        logic       mux_rf;
        logic [1:0] mux_tgt;
        logic       we_rf;
        logic       we_dmem;
        logic       halted;
        logic       err;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] op = '0;
    logic       halt_insn = 1'b0;
    logic       EQ = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, dmem_req, IR_we, PC_we;
    logic [1:0] FUNC_alu, MUX_pc, MUX_tgt;
    logic       MUX_alu1, MUX_alu2, MUX_rf, WE_rf, WE_dmem, halted, err;
`ifdef RISC16_PERF_CNT_EN
    logic [15:0] cyc_cnt, ret_cnt;
    logic [15:0] m_cyc = '0, m_ret = '0;
    bit          cnt_valid = 1'b0;
`endif

    outs_t obs;
    int    checks = 0;
    int    errors = 0;

    risc16_seq_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .halt_insn  (halt_insn),
        .EQ         (EQ),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .IR_we      (IR_we),
        .PC_we      (PC_we),
        .FUNC_alu   (FUNC_alu),
        .MUX_alu1   (MUX_alu1),
        .MUX_alu2   (MUX_alu2),
        .MUX_pc     (MUX_pc),
        .MUX_rf     (MUX_rf),
        .MUX_tgt    (MUX_tgt),
        .WE_rf      (WE_rf),
        .WE_dmem    (WE_dmem),
        .halted     (halted),
        .err        (err)
`ifdef RISC16_PERF_CNT_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .ret_cnt    (ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, dmem_req, IR_we, PC_we, FUNC_alu, MUX_alu1, MUX_alu2,
                  MUX_pc, MUX_rf, MUX_tgt, WE_rf, WE_dmem, halted, err};

    // One clock cycle: compare outputs mid-cycle, then advance past the edge.
    task automatic step(input outs_t exp, input string tag);
        @(negedge clk);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: outputs got %05h expected %05h", tag, obs, exp);
        end
`ifdef RISC16_PERF_CNT_EN
        if (cnt_valid) begin
            checks++;
            assert ({cyc_cnt, ret_cnt} === {m_cyc, m_ret}) else begin
                errors++;
                $error("FAIL %s_cnt: cyc/ret got %0d/%0d expected %0d/%0d",
                       tag, cyc_cnt, ret_cnt, m_cyc, m_ret);
            end
        end
        if (rst) begin
            m_cyc = '0;
            m_ret = '0;
            cnt_valid = 1'b1;
        end else begin
            if (!exp.halted && !exp.err) m_cyc = m_cyc + 16'd1;
            if (exp.pc_we) m_ret = m_ret + 16'd1;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    // Inputs that the current state must ignore get random values.
    task automatic drive_idle();
        op         = 3'($urandom);
        halt_insn  = 1'($urandom);
        EQ         = 1'($urandom);
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
    endtask

    function automatic outs_t exec_exp(input logic [2:0] o, input logic eq);
        outs_t e = '0;
        case (o)
            NAND: e.func_alu = 2'b01;
            LUI: begin
                e.func_alu = 2'b10;
                e.mux_alu1 = 1'b1;
            end
            SW, LW: e.mux_alu2 = 1'b1;
            BEQ: begin
                e.func_alu = 2'b11;
                e.mux_rf   = 1'b1;
                e.pc_we    = 1'b1;
                e.mux_pc   = eq ? 2'b01 : 2'b00;
            end
            JALR: e.func_alu = 2'b10;
            default: e.func_alu = 2'b00;
        endcase
        return e;
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            drive_idle();
            rst = 1'b1;
            step(outs_t'(0), "reset");
        end
        rst = 1'b0;
    endtask

    // Fetch (after di not-ready cycles) and decode one instruction.
    task automatic fetch_decode(input logic [2:0] o, input logic h, input int di,
                                input string tag);
        outs_t e;
        for (int i = 0; i < di; i++) begin
            drive_idle();
            imem_ready = 1'b0;
            e = '0;
            e.imem_req = 1'b1;
            step(e, {tag, "_fetch_wait"});
        end
        drive_idle();
        imem_ready = 1'b1;
        e = '0;
        e.imem_req = 1'b1;
        e.ir_we    = 1'b1;
        step(e, {tag, "_fetch"});
        drive_idle();
        op        = o;
        halt_insn = h;
        step(outs_t'(0), {tag, "_decode"});
    endtask

    // Full instruction from FETCH back to the next FETCH.
    task automatic run_insn(input logic [2:0] o, input logic eq, input int di,
                            input int dd, input string tag);
        outs_t e;
        fetch_decode(o, 1'b0, di, tag);
        drive_idle();
        EQ = eq;
        step(exec_exp(o, eq), {tag, "_exec"});
        if (o == BEQ) return;
        if (o == SW || o == LW) begin
            for (int i = 0; i <= dd; i++) begin
                drive_idle();
                dmem_ready = (i == dd);
                e = '0;
                e.dmem_req = 1'b1;
                e.we_dmem  = (o == SW);
                e.pc_we    = (o == SW) && (i == dd);
                step(e, {tag, "_mem"});
            end
            if (o == SW) return;
        end
        drive_idle();
        e = '0;
        e.we_rf   = 1'b1;
        e.pc_we   = 1'b1;
        e.mux_tgt = (o == LW) ? 2'b00 : (o == JALR) ? 2'b10 : 2'b01;
        e.mux_pc  = (o == JALR) ? 2'b10 : 2'b00;
        step(e, {tag, "_wb"});
    endtask

    initial begin
        outs_t e;
        drive_idle();
        rst = 1'b1;
        do_reset(2);

        // Directed basics.
        run_insn(ADD, 1'b0, 0, 0, "add");
        run_insn(BEQ, 1'b1, 0, 0, "beq_taken");
        run_insn(BEQ, 1'b0, 0, 0, "beq_not_taken");
        run_insn(LW, 1'b0, 0, 3, "lw_wait3");
        run_insn(SW, 1'b0, 0, 0, "sw");
        run_insn(JALR, 1'b0, 0, 0, "jalr");
        run_insn(LUI, 1'b0, 0, 0, "lui");

        // Ready arriving exactly when the wait count reaches TIMEOUT wins.
        run_insn(ADDI, 1'b0, TO, 0, "imem_at_timeout");
        run_insn(SW, 1'b0, 0, TO, "dmem_at_timeout");

        for (int n = 0; n < 40; n++) begin
            run_insn(3'($urandom), 1'($urandom), int'($urandom_range(0, TO)),
                     int'($urandom_range(0, TO)), "rand");
        end

        // Reset in MEM of a store aborts it and restarts fetch.
        fetch_decode(SW, 1'b0, 0, "sw_abort");
        drive_idle();
        step(exec_exp(SW, 1'b0), "sw_abort_exec");
        drive_idle();
        dmem_ready = 1'b0;
        e = '0;
        e.dmem_req = 1'b1;
        e.we_dmem  = 1'b1;
        step(e, "sw_abort_mem");
        drive_idle();
        dmem_ready = 1'b1;
        rst = 1'b1;
        step(outs_t'(0), "sw_abort_rst");
        rst = 1'b0;
        drive_idle();
        imem_ready = 1'b0;
        e = '0;
        e.imem_req = 1'b1;
        step(e, "sw_abort_refetch");
        run_insn(NAND, 1'b0, 0, 0, "after_abort");

        // Store that never completes: five MEM cycles then ERR.
        fetch_decode(SW, 1'b0, 0, "sw_timeout");
        drive_idle();
        step(exec_exp(SW, 1'b0), "sw_timeout_exec");
        for (int i = 0; i <= TO; i++) begin
            drive_idle();
            dmem_ready = 1'b0;
            e = '0;
            e.dmem_req = 1'b1;
            e.we_dmem  = 1'b1;
            step(e, "sw_timeout_mem");
        end
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            e = '0;
            e.err = 1'b1;
            step(e, "sw_timeout_err");
        end
        do_reset(1);

        // Fetch that never completes.
        for (int i = 0; i <= TO; i++) begin
            drive_idle();
            imem_ready = 1'b0;
            e = '0;
            e.imem_req = 1'b1;
            step(e, "fetch_timeout_wait");
        end
        drive_idle();
        e = '0;
        e.err = 1'b1;
        step(e, "fetch_timeout_err");
        do_reset(1);

        // Halt is absorbing; counters (if present) freeze.
        run_insn(ADD, 1'b0, 1, 0, "pre_halt");
        fetch_decode(JALR, 1'b1, 0, "halt");
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            e = '0;
            e.halted = 1'b1;
            step(e, "halt_hold");
        end
        do_reset(1);
        run_insn(ADD, 1'b0, 0, 0, "after_halt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc16_seq_ctrl.md
# risc16_seq_ctrl

Multi-cycle sequencer for the RISC-16 datapath. It replaces single-cycle decoding with a FETCH/DECODE/EXEC/MEM/WB state machine and handshakes with instruction and data memories that have variable latency. In each state it drives the same datapath select and enable fields as the single-cycle decoder, plus IR/PC write strobes. It sits between the instruction register/opcode field and the ALU, register file, PC mux and memory ports.

## Interface
Parameters:
- TIMEOUT, default 15: maximum number of cycles a memory request may wait for ready before the block enters ERR. 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- op  in  3  opcode from IR[15:13]; valid from DECODE onward
- halt_insn  in  1  IR decodes as halt (JALR with nonzero imm); valid with op
- EQ  in  1  register-file operands equal; sampled in EXEC
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- IR_we  out  1  load instruction register
- PC_we  out  1  load PC from the MUX_pc selection
- FUNC_alu  out  2  00 add, 01 nand, 10 pass, 11 compare
- MUX_alu1, MUX_alu2  out  1 each  ALU operand selects
- MUX_pc  out  2  00 PC+1, 01 branch target, 10 ALU/register
- MUX_rf  out  1  register-file second read port select
- MUX_tgt  out  2  00 dmem, 01 ALU, 10 PC+1
- WE_rf, WE_dmem  out  1 each  register-file / data memory write enables
- halted  out  1  block is in HALT
- err  out  1  block is in ERR

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, ERR. Encoding is free.
- FETCH: imem_req=1. When imem_ready=1, IR_we=1 that cycle and next state is DECODE. Otherwise stay in FETCH.
- DECODE: op and halt_insn are latched into op_q/halt_q.
  - If halt_insn=1, go to HALT.
  - Otherwise go to EXEC.
- EXEC: ALU and mux fields are driven from op_q:
  - add/addi 00, nand 01, lui 10 with MUX_alu1=1, lw/sw 00 with MUX_alu2=1, beq 11 with MUX_rf=1, jalr 10.
  - beq: PC_we=1 and MUX_pc=EQ?01:00, then go to FETCH.
  - lw/sw: go to MEM.
  - All other opcodes: go to WB.
- MEM: dmem_req=1, and WE_dmem=1 for sw. dmem_req and WE_dmem are held until dmem_ready.
  - On ready, sw asserts PC_we=1 (MUX_pc=00) and goes to FETCH.
  - On ready, lw goes to WB.
- WB: WE_rf=1 and PC_we=1 for exactly one cycle, then go to FETCH.
  - MUX_tgt: lw 00, jalr 10, others 01.
  - MUX_pc: jalr 10, others 00.
- HALT: absorbing until rst. All enables and requests are 0; halted=1.
- ERR: entered when a wait counter reaches TIMEOUT with ready still low. Absorbing until rst. All enables 0; err=1.
- Every select and enable not listed for a state is 0.
- WE_rf, WE_dmem, PC_we and IR_we each pulse at most once per instruction.
- Ready inputs are ignored in any state where the matching request is 0.

## Timing
- Reset: while rst=1, all outputs are 0 (combinationally gated). The state after the rst edge is FETCH, op_q=0, halt_q=0, wait counter=0.
- Reset asserted mid-instruction (including MEM with WE_dmem high) aborts the instruction: no write enable is asserted in the reset cycle, and fetch restarts at the current PC.
- Zero-wait latencies, FETCH to the next FETCH:
  - add/addi/nand/lui/jalr: 4 cycles
  - beq: 3 cycles
  - sw: 4 cycles
  - lw: 5 cycles
- Each cycle that ready is low adds exactly one cycle in FETCH or MEM.
- Wait counter: cleared on every state entry, increments each cycle in FETCH or MEM while ready=0. When the count equals TIMEOUT (nonzero) and ready=0, the next state is ERR.
- If ready=1 arrives on the same cycle the count reaches TIMEOUT, ready wins and there is no error.
- Outputs are a function of state, op_q and the current EQ/ready inputs only. There are no combinational paths from op to outputs outside DECODE.

## Configuration
- RISC16_PERF_CNT_EN defined:
  - Adds output ports cyc_cnt[15:0] and ret_cnt[15:0], both reset to 0.
  - cyc_cnt increments every cycle not in HALT/ERR.
  - ret_cnt increments on each final PC_we of an instruction.
  - Both wrap 0xFFFF→0x0000 and freeze in HALT/ERR.
- Not defined: neither port nor the counters exist; all other behaviour is identical.

## Test plan
- Reset then add, imem_ready tied 1 → IR_we at cycle 0, WE_rf=1 and PC_we=1 at cycle 3 with MUX_tgt=01, back to FETCH at cycle 4.
- beq with EQ=1, then beq with EQ=0 → PC_we at cycle 2 with MUX_pc=01, then 00; WE_rf stays 0 throughout.
- lw with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles, then WB with MUX_tgt=00; total 8 cycles.
- TIMEOUT=4, sw with dmem_ready never asserted → ERR after 5 MEM cycles, err=1, WE_dmem=0 from then on.
- rst pulsed during MEM of sw → WE_dmem=0 in the reset cycle, FETCH with imem_req=1 on the next cycle.
- halt_insn=1 at DECODE → halted=1 from the next cycle; with RISC16_PERF_CNT_EN, cyc_cnt is frozen and ret_cnt is unchanged.
